// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: one outstanding memory request feeding a DEPTH-entry FIFO toward decode.
// Optional macro FETCH_ALIGN_CHECK_EN flags misaligned redirect targets and stalls fetch while flagged.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    o_Mem_Req,
  output logic [31:0]             o_Mem_Addr,
  input  logic                    i_Mem_Ack,
  input  logic [31:0]             i_Mem_Rdata,
  input  logic                    i_Redirect,
  input  logic [31:0]             i_Redirect_PC,
  output logic                    o_Valid,
  input  logic                    i_Ready,
  output logic [31:0]             o_Instruction,
  output logic [31:0]             o_PC,
  output logic [$clog2(DEPTH):0]  o_Count,
  output logic                    o_Misaligned
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam int               CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ZERO_C = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE_C  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      NOP_C      = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t           state_r, state_next_s;
  logic [31:0]      fetch_pc_r, fetch_pc_next_s;
  logic [31:0]      instr_mem_r [DEPTH];
  logic [31:0]      pc_mem_r    [DEPTH];
  logic [PTR_W-1:0] head_r, tail_r;
  logic [CNT_W-1:0] count_r, count_next_s;
  logic             misaligned_r, misaligned_next_s;
  logic [31:0]      redirect_pc_s;
  logic             req_live_s, ack_s, push_s, pop_s, valid_s;

  // A request is only on the bus when the FSM wants one and fetch is not stalled on a bad target.
  assign req_live_s    = (state_r != IDLE) && !misaligned_r;
  assign ack_s         = i_Mem_Ack && req_live_s;
  assign push_s        = ack_s && (state_r == REQ) && !i_Redirect;
  assign valid_s       = (count_r != CNT_ZERO_C);
  assign pop_s         = valid_s && i_Ready && !i_Redirect;
  assign redirect_pc_s = i_Redirect_PC & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
  // Misaligned flag follows the alignment of the most recent redirect target.
  always_comb begin
    misaligned_next_s = misaligned_r;
    if (i_Redirect) begin
      misaligned_next_s = |i_Redirect_PC[1:0];
    end else begin
      misaligned_next_s = misaligned_r;
    end
  end
`else
  assign misaligned_next_s = 1'b0;
`endif

  // Occupancy update; redirect flushes regardless of push or pop.
  always_comb begin
    count_next_s = count_r;
    if (i_Redirect) begin
      count_next_s = CNT_ZERO_C;
    end else if (push_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE_C;
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CNT_ONE_C;
    end else begin
      count_next_s = count_r;
    end
  end

  // Fetch FSM next state and fetch address.
  always_comb begin
    state_next_s    = state_r;
    fetch_pc_next_s = fetch_pc_r;
    case (state_r)
      IDLE: begin
        if (i_Redirect) begin
          state_next_s = IDLE;
        end else if (count_next_s < FULL_C) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        // An un-acked live request must still be absorbed after a redirect.
        if (i_Redirect) begin
          state_next_s = (req_live_s && !ack_s) ? DROP : REQ;
        end else if (ack_s) begin
          state_next_s = (count_next_s < FULL_C) ? REQ : IDLE;
        end else begin
          state_next_s = REQ;
        end
      end
      DROP: begin
        if (i_Redirect) begin
          state_next_s = req_live_s ? DROP : REQ;
        end else if (ack_s) begin
          state_next_s = REQ;
        end else begin
          state_next_s = DROP;
        end
      end
      default: state_next_s = IDLE;
    endcase
    if (i_Redirect) begin
      fetch_pc_next_s = redirect_pc_s;
    end else if (push_s) begin
      fetch_pc_next_s = fetch_pc_r + 32'd4;
    end else begin
      fetch_pc_next_s = fetch_pc_r;
    end
  end

  // Control state and FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      fetch_pc_r   <= RESET_PC;
      count_r      <= CNT_ZERO_C;
      head_r       <= PTR_ZERO_C;
      tail_r       <= PTR_ZERO_C;
      misaligned_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      fetch_pc_r   <= fetch_pc_next_s;
      count_r      <= count_next_s;
      misaligned_r <= misaligned_next_s;
      if (i_Redirect) begin
        head_r <= PTR_ZERO_C;
        tail_r <= PTR_ZERO_C;
      end else begin
        if (push_s) begin
          tail_r <= tail_r + PTR_ONE_C;
        end
        if (pop_s) begin
          head_r <= head_r + PTR_ONE_C;
        end
      end
    end
  end

  // FIFO storage; contents are qualified by count_r so they need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[tail_r] <= i_Mem_Rdata;
      pc_mem_r[tail_r]    <= fetch_pc_r;
    end
  end

  assign o_Mem_Req     = req_live_s;
  assign o_Mem_Addr    = fetch_pc_r;
  assign o_Valid       = valid_s;
  assign o_Instruction = valid_s ? instr_mem_r[head_r] : NOP_C;
  assign o_PC          = valid_s ? pc_mem_r[head_r] : 32'h0000_0000;
  assign o_Count       = count_r;
  assign o_Misaligned  = misaligned_r;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: memory model, per-cycle scoreboard, vector table and corner sequences.
module tb_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        o_Mem_Req;
  logic [31:0] o_Mem_Addr;
  logic        i_Mem_Ack;
  logic [31:0] i_Mem_Rdata;
  logic        i_Redirect;
  logic [31:0] i_Redirect_PC;
  logic        o_Valid;
  logic        i_Ready;
  logic [31:0] o_Instruction;
  logic [31:0] o_PC;
  logic [2:0]  o_Count;
  logic        o_Misaligned;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .o_Mem_Req(o_Mem_Req), .o_Mem_Addr(o_Mem_Addr),
    .i_Mem_Ack(i_Mem_Ack), .i_Mem_Rdata(i_Mem_Rdata),
    .i_Redirect(i_Redirect), .i_Redirect_PC(i_Redirect_PC),
    .o_Valid(o_Valid), .i_Ready(i_Ready),
    .o_Instruction(o_Instruction), .o_PC(o_PC),
    .o_Count(o_Count), .o_Misaligned(o_Misaligned)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: auto-ack after mem_lat cycles of request, or manual ack when man_en.
  int unsigned wait_cnt;
  int unsigned mem_lat = 1;
  logic        stream = 1'b0;
  logic        man_en = 1'b0;
  logic        man_ack = 1'b0;

  assign i_Mem_Ack   = man_en ? (man_ack && o_Mem_Req) : (o_Mem_Req && (wait_cnt >= mem_lat));
  assign i_Mem_Rdata = mem_fn(o_Mem_Addr);

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (!o_Mem_Req) wait_cnt <= 0;
    else if (i_Mem_Ack && !stream) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Scoreboard: expected entries pushed on accepted acks, popped and compared on consume.
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr = RESET_PC;
  logic        drop_pend = 1'b0;

  always @(negedge clk) begin
    logic [63:0] e;
    #3;
    if (reset) begin
      exp_q.delete();
      exp_addr = RESET_PC;
      drop_pend = 1'b0;
    end else begin
      chk("sb_count", 32'(o_Count), 32'(exp_q.size()));
      chk("sb_valid", 32'(o_Valid), 32'(exp_q.size() != 0));
      if (!o_Valid) begin
        chk("sb_nop", o_Instruction, NOP);
        chk("sb_pc_zero", o_PC, 32'h0);
      end
      if (exp_q.size() == DEPTH) chk("sb_full_no_req", 32'(o_Mem_Req), 32'd0);
      if (o_Valid && i_Ready && !i_Redirect && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pop_pc", o_PC, e[63:32]);
        chk("sb_pop_instr", o_Instruction, e[31:0]);
      end
      if (o_Mem_Req && i_Mem_Ack && !drop_pend && !i_Redirect) begin
        chk("sb_fetch_addr", o_Mem_Addr, exp_addr);
        exp_q.push_back({exp_addr, mem_fn(exp_addr)});
        exp_addr = exp_addr + 32'd4;
      end
      if (i_Redirect) begin
        exp_q.delete();
        exp_addr = i_Redirect_PC & 32'hFFFF_FFFC;
        drop_pend = o_Mem_Req && (drop_pend || !i_Mem_Ack);
      end else if (o_Mem_Req && i_Mem_Ack) begin
        drop_pend = 1'b0;
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[6];

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(o_Mem_Req), 32'd0);
    chk({tag, "_valid"}, 32'(o_Valid), 32'd0);
    chk({tag, "_count"}, 32'(o_Count), 32'd0);
    chk({tag, "_mis"}, 32'(o_Misaligned), 32'd0);
    chk({tag, "_instr"}, o_Instruction, NOP);
    chk({tag, "_pc"}, o_PC, 32'h0);
  endtask

  task automatic do_reset(input logic rdy, input int unsigned lat, input logic strm);
    @(negedge clk);
    reset = 1'b1;
    i_Redirect = 1'b0;
    man_en = 1'b0;
    man_ack = 1'b0;
    i_Ready = rdy;
    mem_lat = lat;
    stream = strm;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    //                 rdy   req   addr          valid pc            count
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 3'd0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 3'd0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 3'd1};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 3'd1};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 3'd1};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C, 3'd1};

    reset = 1'b1;
    i_Ready = 1'b0;
    i_Redirect = 1'b0;
    i_Redirect_PC = 32'h0;
    @(negedge clk);
    #1 chk_reset_vals("rst_init");

    // Streaming fetch from reset: ack every cycle after one cycle of latency.
    do_reset(1'b1, 1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      i_Ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_req", i), 32'(o_Mem_Req), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_addr", i), o_Mem_Addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), 32'(o_Valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_pc", i), o_PC, vecs[i].exp_pc);
      chk($sformatf("vec%0d_instr", i), o_Instruction,
          vecs[i].exp_valid ? mem_fn(vecs[i].exp_pc) : NOP);
      chk($sformatf("vec%0d_count", i), 32'(o_Count), 32'(vecs[i].exp_count));
    end

    // Fill to DEPTH with decode stalled, then a single pop re-enables fetch of 0x10.
    do_reset(1'b0, 1, 1'b1);
    n = 0;
    while (o_Count != 3'd4 && n < 30) begin @(negedge clk); n++; end
    chk("full_count", 32'(o_Count), 32'd4);
    chk("full_req", 32'(o_Mem_Req), 32'd0);
    i_Ready = 1'b1;
    @(negedge clk);
    i_Ready = 1'b0;
    #1;
    chk("pop_reissue_req", 32'(o_Mem_Req), 32'd1);
    chk("pop_reissue_addr", o_Mem_Addr, 32'h0000_0010);
    chk("pop_count", 32'(o_Count), 32'd3);

    // Redirect while the 0x8 request is pending; its late ack is discarded.
    do_reset(1'b0, 1, 1'b0);
    n = 0;
    while (!(o_Mem_Req && o_Mem_Addr == 32'h8) && n < 30) begin @(negedge clk); n++; end
    chk("wait_addr8", o_Mem_Addr, 32'h0000_0008);
    man_en = 1'b1;
    man_ack = 1'b0;
    i_Redirect = 1'b1;
    i_Redirect_PC = 32'h0000_0040;
    @(negedge clk);
    i_Redirect = 1'b0;
    #1;
    chk("drop_valid", 32'(o_Valid), 32'd0);
    chk("drop_req_held", 32'(o_Mem_Req), 32'd1);
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    man_en = 1'b0;
    #1;
    chk("drop_after_req", 32'(o_Mem_Req), 32'd1);
    chk("drop_after_addr", o_Mem_Addr, 32'h0000_0040);
    chk("drop_after_count", 32'(o_Count), 32'd0);
    i_Ready = 1'b1;
    n = 0;
    while (!o_Valid && n < 20) begin @(negedge clk); n++; end
    chk("drop_first_pc", o_PC, 32'h0000_0040);
    chk("drop_first_instr", o_Instruction, mem_fn(32'h0000_0040));

    // Redirect coinciding with ack and pop.
    do_reset(1'b1, 1, 1'b1);
    n = 0;
    while (!(o_Valid && i_Mem_Ack) && n < 30) begin @(negedge clk); n++; end
    chk("ackpop_ready", 32'(o_Valid && i_Mem_Ack), 32'd1);
    i_Redirect = 1'b1;
    i_Redirect_PC = 32'h0000_0080;
    @(negedge clk);
    i_Redirect = 1'b0;
    #1;
    chk("ackpop_valid", 32'(o_Valid), 32'd0);
    chk("ackpop_count", 32'(o_Count), 32'd0);
    chk("ackpop_req", 32'(o_Mem_Req), 32'd1);
    chk("ackpop_addr", o_Mem_Addr, 32'h0000_0080);

    // Asynchronous reset with three entries and a request outstanding.
    do_reset(1'b0, 1, 1'b0);
    n = 0;
    while (!(o_Count == 3'd3 && o_Mem_Req) && n < 30) begin @(negedge clk); n++; end
    chk("pre_rst_count", 32'(o_Count), 32'd3);
    man_en = 1'b1;
    man_ack = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    man_en = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_req", 32'(o_Mem_Req), 32'd1);
    chk("post_rst_addr", o_Mem_Addr, RESET_PC);

    // Misaligned redirect target.
    do_reset(1'b0, 1, 1'b1);
    repeat (3) @(negedge clk);
    i_Redirect = 1'b1;
    i_Redirect_PC = 32'h0000_0042;
    @(negedge clk);
    i_Redirect = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_flag_set", 32'(o_Misaligned), 32'd1);
    chk("mis_req_off", 32'(o_Mem_Req), 32'd0);
    repeat (3) @(negedge clk);
    #1 chk("mis_req_still_off", 32'(o_Mem_Req), 32'd0);
    @(negedge clk);
    i_Redirect = 1'b1;
    i_Redirect_PC = 32'h0000_0044;
    @(negedge clk);
    i_Redirect = 1'b0;
    #1;
    chk("mis_flag_clr", 32'(o_Misaligned), 32'd0);
    i_Ready = 1'b1;
    n = 0;
    while (!o_Valid && n < 20) begin @(negedge clk); n++; end
    chk("mis_fetch_pc", o_PC, 32'h0000_0044);
`else
    chk("mis_tied_low", 32'(o_Misaligned), 32'd0);
    chk("mis_forced_addr", o_Mem_Addr, 32'h0000_0040);
    i_Ready = 1'b1;
    n = 0;
    while (!o_Valid && n < 20) begin @(negedge clk); n++; end
    chk("mis_forced_pc", o_PC, 32'h0000_0040);
`endif

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
